mul_mod_d: RTL and testbench

MUL_MOD_D -- requirements
Module: mul_mod_d

---
 rtl/mul_mod_d_pkg.sv | 15 +
 rtl/mul_mod_d_if.sv | 24 ++
 rtl/mul_mod_d_red_d.sv | 26 ++
 rtl/mul_mod_d.sv | 79 +++++++
 tb/tb_mul_mod_d.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mul_mod_d_pkg.sv
// Shared constants for the Dilithium modular multiplier: modulus, operand and product widths,
// plus the operand range check used on entry to the pipeline.
package mul_mod_d_pkg;

    localparam int OP_W   = 23;
    localparam int PROD_W = 46;
    localparam int FOLD_SHIFT = 13;

    localparam logic [OP_W-1:0] Q_D = 23'd8380417;

    function automatic logic operands_in_range(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        return (a < Q_D) && (b < Q_D);
    endfunction

endpackage

// File: rtl/mul_mod_d_if.sv
// Operand/result handshake bundle for mul_mod_d; the slave modport is the multiplier side.
interface mul_mod_d_if;
    import mul_mod_d_pkg::*;

    logic [OP_W-1:0] a_i;
    logic [OP_W-1:0] b_i;
    logic            valid_i;
    logic            ready_o;
    logic [OP_W-1:0] result_o;
    logic            err_o;
    logic            valid_o;
    logic            ready_i;

    modport slave (
        input  a_i, b_i, valid_i, ready_i,
        output ready_o, result_o, err_o, valid_o
    );

    modport master (
        output a_i, b_i, valid_i, ready_i,
        input  ready_o, result_o, err_o, valid_o
    );

endinterface

// File: rtl/mul_mod_d_red_d.sv
// Combinational reduction of a product below Q_D^2 into [0, Q_D-1].
// Uses 2^23 == 2^13 - 1 (mod Q_D) to fold the upper bits three times, then one conditional subtract.
module red_d
    import mul_mod_d_pkg::*;
(
    input  logic [PROD_W-1:0] product_i,
    output logic [OP_W-1:0]   result_o
);

    logic [35:0] fold1_s;
    logic [26:0] fold2_s;
    logic [23:0] fold3_s;

    // Each fold maps hi*2^23 + lo to lo + hi*2^13 - hi; intermediate wrap is harmless since the true value fits.
    always_comb begin
        fold1_s = 36'(product_i[22:0]) + (36'(product_i[45:23]) << FOLD_SHIFT) - 36'(product_i[45:23]);
        fold2_s = 27'(fold1_s[22:0]) + (27'(fold1_s[35:23]) << FOLD_SHIFT) - 27'(fold1_s[35:23]);
        fold3_s = 24'(fold2_s[22:0]) + (24'(fold2_s[26:23]) << FOLD_SHIFT) - 24'(fold2_s[26:23]);
        if (fold3_s >= {1'b0, Q_D}) begin
            result_o = 23'(fold3_s - {1'b0, Q_D});
        end else begin
            result_o = fold3_s[22:0];
        end
    end

endmodule

// File: rtl/mul_mod_d.sv
// Three-stage (a*b) mod Q_D pipeline with a single global advance enable driven by output backpressure.
module mul_mod_d
    import mul_mod_d_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    mul_mod_d_if.slave  bus
);

    logic              en_s;
    logic [OP_W-1:0]   red_s;

    logic              s1_vld_r;
    logic              s1_err_r;
    logic [OP_W-1:0]   s1_a_r;
    logic [OP_W-1:0]   s1_b_r;

    logic              s2_vld_r;
    logic              s2_err_r;
    logic [PROD_W-1:0] s2_prod_r;

    logic              s3_vld_r;
    logic              s3_err_r;
    logic [OP_W-1:0]   s3_res_r;

    assign en_s        = !s3_vld_r || bus.ready_i;
    assign bus.ready_o = en_s;

    assign bus.valid_o  = s3_vld_r;
    assign bus.err_o    = s3_err_r;
    assign bus.result_o = s3_res_r;

    red_d u_red (
        .product_i (s2_prod_r),
        .result_o  (red_s)
    );

    // Stage 1: capture operands and their range flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_r <= 1'b0;
            s1_err_r <= 1'b0;
            s1_a_r   <= 23'd0;
            s1_b_r   <= 23'd0;
        end else if (en_s) begin
            s1_vld_r <= bus.valid_i;
            s1_err_r <= bus.valid_i && !operands_in_range(bus.a_i, bus.b_i);
            s1_a_r   <= bus.a_i;
            s1_b_r   <= bus.b_i;
        end
    end

    // Stage 2: full-width product, never truncated.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_vld_r  <= 1'b0;
            s2_err_r  <= 1'b0;
            s2_prod_r <= 46'd0;
        end else if (en_s) begin
            s2_vld_r  <= s1_vld_r;
            s2_err_r  <= s1_err_r;
            s2_prod_r <= PROD_W'(s1_a_r) * PROD_W'(s1_b_r);
        end
    end

    // Stage 3: reduced result; zero whenever the beat is empty or flagged out of range.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s3_vld_r <= 1'b0;
            s3_err_r <= 1'b0;
            s3_res_r <= 23'd0;
        end else if (en_s) begin
            s3_vld_r <= s2_vld_r;
            s3_err_r <= s2_vld_r && s2_err_r;
            s3_res_r <= (s2_vld_r && !s2_err_r) ? red_s : 23'd0;
        end
    end

endmodule

// File: tb/tb_mul_mod_d.sv
// Directed and randomised checks of mul_mod_d against hand-computed values and a (a*b) mod q model.
module tb_mul_mod_d;
    import mul_mod_d_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_mod_d_if bus ();

    mul_mod_d dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [22:0] exp_res_q[$];
    logic        exp_err_q[$];
    logic [22:0] cur_res;
    logic        cur_err;
    int checks = 0;
    int errors = 0;
    int n_acc  = 0;

    function automatic logic [22:0] mref(input logic [22:0] a, input logic [22:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return 23'(p % 64'd8380417);
    endfunction

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard bookkeeping for the current cycle, then advance one clock.
    task automatic tick();
        #1;
        if (bus.valid_o && bus.ready_i) begin
            if (exp_res_q.size() == 0) begin
                chk("spurious_output", 1, 0);
            end else begin
                chk("result", bus.result_o, exp_res_q.pop_front());
                chk("err", bus.err_o, exp_err_q.pop_front());
            end
        end
        if (!bus.valid_o) begin
            chk("idle_result_zero", bus.result_o, 0);
            chk("idle_err_zero", bus.err_o, 0);
        end
        if (bus.valid_i && bus.ready_o) begin
            exp_res_q.push_back(cur_res);
            exp_err_q.push_back(cur_err);
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [22:0] a, input logic [22:0] b,
                         input logic [22:0] res, input logic err);
        bus.a_i     = a;
        bus.b_i     = b;
        bus.valid_i = 1'b1;
        cur_res     = res;
        cur_err     = err;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        while (exp_res_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain_empty", exp_res_q.size(), 0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.a_i     = 23'd0;
        bus.b_i     = 23'd0;
        bus.ready_i = 1'b1;
        cur_res     = 23'd0;
        cur_err     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_valid_o", bus.valid_o, 0);
        chk("reset_result_o", bus.result_o, 0);
        chk("reset_err_o", bus.err_o, 0);
        chk("reset_ready_o", bus.ready_o, 1);

        // Latency: visible exactly three cycles after acceptance.
        drive(23'd1, 23'd838041, 23'd838041, 1'b0);
        tick();
        bus.valid_i = 1'b0;
        chk("lat_c1_valid", bus.valid_o, 0);
        tick();
        chk("lat_c2_valid", bus.valid_o, 0);
        tick();
        chk("lat_c3_valid", bus.valid_o, 1);
        chk("lat_c3_result", bus.result_o, 838041);
        chk("lat_c3_err", bus.err_o, 0);
        tick();

        // Back-to-back stream, then a five-cycle stall.
        drive(23'd2, 23'd4190209, 23'd1, 1'b0);
        tick();
        drive(23'd8380416, 23'd8380416, 23'd1, 1'b0);
        tick();
        drive(23'd4000000, 23'd3, 23'd3619583, 1'b0);
        tick();
        drive(23'd1, 23'd838041, 23'd838041, 1'b0);
        tick();
        drive(23'd5, 23'd7, 23'h7FFFFF, 1'b1);
        bus.ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_ready_o", bus.ready_o, 0);
            chk("stall_valid_o", bus.valid_o, 1);
            chk("stall_result_o", bus.result_o, 1);
            chk("stall_err_o", bus.err_o, 0);
            tick();
        end
        drain();

        // Out-of-range operand followed by a normal pair.
        drive(23'd8380417, 23'd5, 23'd0, 1'b1);
        tick();
        drive(23'd4000000, 23'd3, 23'd3619583, 1'b0);
        tick();
        drain();

        // Reset with two pairs in flight.
        drive(23'd1, 23'd1, 23'd1, 1'b0);
        tick();
        drive(23'd2, 23'd2, 23'd4, 1'b0);
        tick();
        bus.valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_res_q.delete();
        exp_err_q.delete();
        #1;
        chk("midrst_valid_o", bus.valid_o, 0);
        chk("midrst_ready_o", bus.ready_o, 1);
        chk("midrst_result_o", bus.result_o, 0);
        for (int i = 0; i < 5; i++) begin
            chk("midrst_no_stale", bus.valid_o, 0);
            tick();
        end

        // Random traffic with random backpressure.
        n_acc = 0;
        for (int guard = 0; guard < 60000 && n_acc < 10000; guard++) begin
            bus.a_i     = 23'($urandom_range(0, 8380416));
            bus.b_i     = 23'($urandom_range(0, 8380416));
            bus.valid_i = ($urandom_range(0, 3) != 0);
            bus.ready_i = ($urandom_range(0, 3) != 0);
            cur_res     = mref(bus.a_i, bus.b_i);
            cur_err     = 1'b0;
            tick();
        end
        chk("random_accepted", n_acc, 10000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
